title_draw: RTL and testbench
=============================

Name: title_draw

Overview:
Initiator side of the title-image ROM interface. Walks the VGA timing stream, issues word addresses to the 24-bit title ROM (one-cycle registered read), and overlays the returned pixels on the incoming RGB stream inside a fixed window. Sits in the menu video pipeline between the background stage and the VGA output register. All timing signals are delayed to stay aligned with the ROM latency.

Parameters:
XPOS, 189, left edge of title window (pixels)
YPOS, 100, top edge of title window (lines)
WIDTH, 262, title width in pixels
HEIGHT, 100, title height in lines (WIDTH*HEIGHT = 26200 = ROM depth)
KEY_COLOR, 24'h000000, ROM pixel value treated as transparent
BLINK_FRAMES, 30, frames per blink half-period (only with TITLE_BLINK_EN)

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous, active-high reset
enable  input  1  request title display
hcount_in  input  11  horizontal pixel counter
vcount_in  input  11  vertical line counter
hsync_in  input  1  horizontal sync
vsync_in  input  1  vertical sync
hblnk_in  input  1  horizontal blanking
vblnk_in  input  1  vertical blanking
rgb_in  input  12  background colour {R4,G4,B4}
rom_addr  output  20  ROM address; bits[19:2] = word index, bits[1:0] = 2'b00
rom_pixel  input  24  ROM data {R8,G8,B8}, valid one clk after rom_addr
hcount_out, vcount_out  output  11 each  delayed counters
hsync_out, vsync_out, hblnk_out, vblnk_out  output  1 each  delayed timing
rgb_out  output  12  composited colour

Behaviour:
- Reset: all outputs 0; state OFF; delay pipeline cleared; frame counter 0.
- Frame boundary event: vblnk_in rising edge (registered previous value, 0 -> 1).
- FSM: OFF -> ARM when enable=1. ARM -> ON on frame boundary; ARM -> OFF if enable=0. ON -> OFF on frame boundary when enable=0; enable=0 mid-frame keeps title until end of frame. Title never appears or disappears mid-frame.
- In-window (stage 0, combinational on inputs): XPOS <= hcount_in < XPOS+WIDTH and YPOS <= vcount_in < YPOS+HEIGHT, hblnk_in=0, vblnk_in=0.
- Row base: 18-bit register; cleared on frame boundary; incremented by WIDTH on the cycle hcount_in = XPOS+WIDTH-1 when vcount_in is inside the window rows. Word index = row_base + (hcount_in - XPOS). No multiplier.
- Stage 1 (n+1): rom_addr <= {word_idx, 2'b00} when in-window, else 20'd0; in-window flag and all timing/rgb registered.
- Stage 2 (n+2): rom_pixel valid; timing/rgb/flag registered again.
- Stage 3 (n+3): outputs registered. rgb_out = {rom_pixel[23:20], rom_pixel[15:12], rom_pixel[7:4]} when flag=1, state=ON, visible, and rom_pixel != KEY_COLOR; else delayed rgb_in.
- Total latency input -> output: 3 clk for every signal, uniform.
- Word index never exceeds WIDTH*HEIGHT-1; out-of-window addresses are 0.
- rst mid-frame: pipeline flushed, state OFF; rgb_out shows 0 for 3 clk, then passthrough.

Optional Feature:
TITLE_BLINK_EN defined: 8-bit frame counter increments on each frame boundary while ON, wraps at 2*BLINK_FRAMES-1 to 0; title visible when counter < BLINK_FRAMES, hidden otherwise; counter cleared on entry to ON. Undefined: no counter, title always visible while ON.

Test Plan:
- Reset, then enable=1 mid-frame -> no overlay that frame; overlay from next frame after vblnk rising edge.
- hcount=XPOS, vcount=YPOS, ON -> rom_addr=20'd0 at n+1; rom_pixel=24'hF08040 -> rgb_out=12'hF84 at n+3, timing outputs equal inputs delayed 3 clk.
- hcount=XPOS+WIDTH-1, vcount=YPOS+HEIGHT-1 -> rom_addr={18'd26199,2'b00}; next row start after YPOS -> word index 262.
- rom_pixel=KEY_COLOR or pixel outside window -> rgb_out = rgb_in delayed 3 clk, rom_addr=0 outside window.
- enable dropped mid-frame while ON -> title stays to end of frame, OFF after boundary.
- TITLE_BLINK_EN, BLINK_FRAMES=2 -> visible frames 0,1, hidden 2,3, visible 4 after entering ON.

Source files
------------

// File: rtl/title_draw.sv
`default_nettype none
// ============================================================================
// Module   : title_draw
// Purpose  : Title-image overlay for the menu video pipeline. Walks the VGA
//            timing stream, issues word addresses to the 24-bit title ROM
//            (one-cycle registered read) and composites the returned pixels
//            over the incoming background inside a fixed window. Every
//            timing, counter and colour signal leaves exactly 3 clk after
//            it entered, so the overlay stays aligned with the ROM latency.
//
// Ports    : clk, rst                 pixel clock, synchronous active-high reset
//            enable                   request title display (applied per frame)
//            hcount_in, vcount_in     raster counters (11 bit)
//            hsync_in, vsync_in       sync inputs
//            hblnk_in, vblnk_in       blanking inputs
//            rgb_in                   background colour {R4,G4,B4}
//            rom_addr                 byte address to title ROM, {word_idx,2'b00}
//            rom_pixel                ROM data {R8,G8,B8}, valid 1 clk after addr
//            hcount_out .. vblnk_out  timing delayed by 3 clk
//            rgb_out                  composited colour
//
// Options  : TITLE_BLINK_EN - when defined, the title blinks with a half
//            period of BLINK_FRAMES frames while displayed.
//
// Revision : 1.0 - initial release
// ============================================================================
module title_draw #(
    parameter int          XPOS         = 189,
    parameter int          YPOS         = 100,
    parameter int          WIDTH        = 262,
    parameter int          HEIGHT       = 100,
    parameter logic [23:0] KEY_COLOR    = 24'h000000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [19:0] rom_addr,
    input  logic [23:0] rom_pixel,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Window bounds sized to the counter width so comparisons stay 11 bit.
    localparam logic [10:0] c_x_lo   = 11'(XPOS);
    localparam logic [10:0] c_x_hi   = 11'(XPOS + WIDTH);
    localparam logic [10:0] c_x_last = 11'(XPOS + WIDTH - 1);
    localparam logic [10:0] c_y_lo   = 11'(YPOS);
    localparam logic [10:0] c_y_hi   = 11'(YPOS + HEIGHT);
    localparam logic [17:0] c_width  = 18'(WIDTH);

    localparam logic [1:0] c_s_off = 2'd0;
    localparam logic [1:0] c_s_arm = 2'd1;
    localparam logic [1:0] c_s_on  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        r_vblnk_prev;
    logic        w_frame;
    logic        w_row_in;
    logic        w_win;
    logic [10:0] w_col;
    logic [17:0] w_word_idx;
    logic [17:0] r_row_base;
    logic        w_visible;
    logic        w_show;

    // Timing bundle {hcount, vcount, hsync, vsync, hblnk, vblnk}.
    logic [25:0] w_tim;
    logic [25:0] r1_tim;
    logic [25:0] r2_tim;
    logic [11:0] r1_rgb;
    logic [11:0] r2_rgb;
    logic        r1_win;
    logic        r2_win;

    // ------------------------------------------------------------------------
    // Frame boundary: rising edge of vertical blanking.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_prev <= 1'b0;
        end else begin
            r_vblnk_prev <= vblnk_in;
        end
    end

    assign w_frame = vblnk_in & ~r_vblnk_prev;

    // ------------------------------------------------------------------------
    // Display FSM. Transitions into or out of ON happen only on a frame
    // boundary, so the title is never cut in half vertically.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_off;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_off: begin
                if (enable) w_state_nxt = c_s_arm;
            end
            c_s_arm: begin
                if (!enable)      w_state_nxt = c_s_off;
                else if (w_frame) w_state_nxt = c_s_on;
            end
            c_s_on: begin
                if (w_frame && !enable) w_state_nxt = c_s_off;
            end
            default: w_state_nxt = c_s_off;
        endcase
    end

    // ------------------------------------------------------------------------
    // Blink control.
    // ------------------------------------------------------------------------
`ifdef TITLE_BLINK_EN
    localparam logic [7:0] c_blink_half = 8'(BLINK_FRAMES);
    localparam logic [7:0] c_blink_last = 8'(2 * BLINK_FRAMES - 1);

    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 8'd0;
        end else if ((r_state != c_s_on) && (w_state_nxt == c_s_on)) begin
            // Every display period starts with a visible frame.
            r_frame_cnt <= 8'd0;
        end else if ((r_state == c_s_on) && w_frame) begin
            r_frame_cnt <= (r_frame_cnt == c_blink_last) ? 8'd0 : r_frame_cnt + 8'd1;
        end
    end

    assign w_visible = (r_frame_cnt < c_blink_half);
`else
    assign w_visible = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Stage 0: window decode and address generation.
    // The row base walks in steps of WIDTH instead of multiplying the row
    // number; it advances on the last pixel of each window row, after that
    // pixel has used the current base.
    // ------------------------------------------------------------------------
    assign w_row_in = (vcount_in >= c_y_lo) && (vcount_in < c_y_hi);
    assign w_win    = (hcount_in >= c_x_lo) && (hcount_in < c_x_hi) && w_row_in &&
                      !hblnk_in && !vblnk_in;
    assign w_col      = hcount_in - c_x_lo;
    assign w_word_idx = r_row_base + 18'(w_col);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_base <= 18'd0;
        end else if (w_frame) begin
            r_row_base <= 18'd0;
        end else if ((hcount_in == c_x_last) && w_row_in) begin
            r_row_base <= r_row_base + c_width;
        end
    end

    assign w_tim = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

    // ------------------------------------------------------------------------
    // Stages 1 and 2: address out, then wait for the ROM data.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= 20'd0;
            r1_tim   <= '0;
            r1_rgb   <= 12'd0;
            r1_win   <= 1'b0;
            r2_tim   <= '0;
            r2_rgb   <= 12'd0;
            r2_win   <= 1'b0;
        end else begin
            rom_addr <= w_win ? {w_word_idx, 2'b00} : 20'd0;
            r1_tim   <= w_tim;
            r1_rgb   <= rgb_in;
            r1_win   <= w_win;
            r2_tim   <= r1_tim;
            r2_rgb   <= r1_rgb;
            r2_win   <= r1_win;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: composite and register outputs. Key-coloured ROM pixels let
    // the background through; the top nibble of each channel is kept.
    // ------------------------------------------------------------------------
    assign w_show = r2_win && (r_state == c_s_on) && w_visible && (rom_pixel != KEY_COLOR);

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= r2_tim[25:15];
            vcount_out <= r2_tim[14:4];
            hsync_out  <= r2_tim[3];
            vsync_out  <= r2_tim[2];
            hblnk_out  <= r2_tim[1];
            vblnk_out  <= r2_tim[0];
            rgb_out    <= w_show ? {rom_pixel[23:20], rom_pixel[15:12], rom_pixel[7:4]} : r2_rgb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_title_draw.sv
`default_nettype none
// ============================================================================
// Module   : tb_title_draw
// Purpose  : Self-checking bench for title_draw. Drives a sparse raster
//            (each line samples the window edges plus random columns) with
//            random background colours, models the title ROM, and compares
//            every cycle against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_title_draw;

    localparam int          XPOS      = 189;
    localparam int          YPOS      = 100;
    localparam int          WIDTH     = 262;
    localparam int          HEIGHT    = 100;
    localparam logic [23:0] KEY_COLOR = 24'h000000;
    localparam int          BF        = 2;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        enable    = 1'b0;
    logic [10:0] hcount_in = 11'd0;
    logic [10:0] vcount_in = 11'd0;
    logic        hsync_in  = 1'b0;
    logic        vsync_in  = 1'b0;
    logic        hblnk_in  = 1'b0;
    logic        vblnk_in  = 1'b0;
    logic [11:0] rgb_in    = 12'd0;
    logic [19:0] rom_addr;
    logic [23:0] rom_pixel = 24'd0;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    always #5 clk = ~clk;

    title_draw #(
        .BLINK_FRAMES (BF)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .rom_addr   (rom_addr),
        .rom_pixel  (rom_pixel),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    // Title ROM content: word 0 is a fixed colour, the rest pseudo-random
    // with roughly one in eight words transparent.
    function automatic logic [23:0] rom_fn(input logic [17:0] idx);
        logic [31:0] h;
        if (idx == 18'd0) return 24'hF08040;
        h = {14'd0, idx} * 32'h9E3779B1;
        h = h ^ (h >> 13);
        if (h[2:0] == 3'd0) return KEY_COLOR;
        return h[31:8];
    endfunction

    function automatic logic [11:0] rgb12(input logic [23:0] p);
        return {p[23:20], p[15:12], p[7:4]};
    endfunction

    always @(posedge clk) rom_pixel <= rom_fn(rom_addr[19:2]);

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    logic [19:0] ea [8];
    logic [11:0] er [8];
    logic [25:0] et [8];
    int          cyc      = 0;
    logic        model_on = 1'b0;
    logic        en_prev  = 1'b0;
    logic        rst_prev = 1'b1;
    logic        vb_prev  = 1'b0;
    int          blink    = 0;

    // One pixel clock: check the outputs due now, then drive the next inputs
    // and record what they must produce.
    task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hs,
                        input logic vs, input logic hb, input logic vb,
                        input logic en, input logic r);
        logic        win;
        logic        vis;
        logic        on_next;
        int          idx;
        logic [23:0] pix;
        logic [11:0] rgb;
        @(negedge clk);
        check("rom_addr", 32'(rom_addr), 32'(ea[(cyc - 1) & 7]));
        check("rgb_out", 32'(rgb_out), 32'(er[(cyc - 3) & 7]));
        check("timing_out",
              32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
              32'(et[(cyc - 3) & 7]));

        // Frame-level display decision: a new frame shows the title if enable is
        // high at the boundary and the title was already up or enable had been
        // requested (outside reset) on the cycle before.
        if (r) begin
            model_on = 1'b0;
            blink    = 0;
        end else if (vb && !vb_prev) begin
            on_next = en && (model_on || (en_prev && !rst_prev));
`ifdef TITLE_BLINK_EN
            if (on_next) blink = model_on ? (blink + 1) % (2 * BF) : 0;
`endif
            model_on = on_next;
        end
`ifdef TITLE_BLINK_EN
        vis = (blink < BF);
`else
        vis = 1'b1;
`endif

        rgb       = 12'($urandom);
        hcount_in = h;
        vcount_in = v;
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        enable    = en;
        rst       = r;
        rgb_in    = rgb;

        win = !hb && !vb && (int'(h) >= XPOS) && (int'(h) < XPOS + WIDTH) &&
              (int'(v) >= YPOS) && (int'(v) < YPOS + HEIGHT);
        idx = win ? (int'(v) - YPOS) * WIDTH + (int'(h) - XPOS) : 0;
        pix = rom_fn(18'(idx));
        ea[cyc & 7] = win ? 20'(idx * 4) : 20'd0;
        er[cyc & 7] = (win && model_on && vis && (pix != KEY_COLOR)) ? rgb12(pix) : rgb;
        et[cyc & 7] = {h, v, hs, vs, hb, vb};
        if (r) begin
            // Reset flushes everything in flight, including this cycle's input.
            ea[cyc & 7]       = 20'd0;
            er[cyc & 7]       = 12'd0;
            et[cyc & 7]       = 26'd0;
            er[(cyc - 1) & 7] = 12'd0;
            et[(cyc - 1) & 7] = 26'd0;
            er[(cyc - 2) & 7] = 12'd0;
            et[(cyc - 2) & 7] = 26'd0;
        end
        en_prev  = en;
        rst_prev = r;
        vb_prev  = r ? 1'b0 : vb;
        cyc++;
    endtask

    // One raster line, sampled sparsely: window edges, random interior columns
    // (all before the last window column), a few outside columns, then blanking.
    task automatic run_line(input int v, input logic vb, input logic vs, input logic en,
                            input logic do_rst, input logic glitch);
        int   h;
        logic hb;
        logic hs;
        logic e;
        logic r;
        for (int i = 0; i < 15; i++) begin
            hb = 1'b0;
            hs = 1'b0;
            e  = en;
            r  = 1'b0;
            case (i)
                0:             begin h = int'($urandom_range(0, XPOS - 2)); r = do_rst; end
                1:             h = XPOS - 1;
                2:             h = XPOS;
                3, 4, 5, 6, 7: h = int'($urandom_range(XPOS, XPOS + WIDTH - 2));
                8:             h = XPOS + WIDTH - 1;
                9:             h = XPOS + WIDTH;
                10:            h = int'($urandom_range(XPOS + WIDTH + 1, 799));
                11:            h = 799;
                12:            begin h = 800; hb = 1'b1; end
                13:            begin h = 850; hb = 1'b1; hs = 1'b1; end
                default:       begin h = 1000; hb = 1'b1; end
            endcase
            if (glitch && (i >= 3) && (i <= 5)) e = 1'b0;
            step(11'(h), 11'(v), hs, vs, hb, vb, e, r);
        end
    endtask

    // One frame: enable is en_a for the upper half and en_b from the middle
    // line on; optional single-cycle reset on line rst_v.
    task automatic run_frame(input logic en_a, input logic en_b, input int rst_v,
                             input logic glitch);
        for (int v = YPOS - 3; v <= YPOS + HEIGHT + 2; v++) begin
            run_line(v, 1'b0, 1'b0, (v < YPOS + HEIGHT / 2) ? en_a : en_b,
                     v == rst_v, glitch && (v == YPOS + HEIGHT / 2));
        end
        for (int v = 600; v <= 602; v++) begin
            run_line(v, 1'b1, v == 601, en_b, 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            ea[i] = 20'd0;
            er[i] = 12'd0;
            et[i] = 26'd0;
        end
        repeat (3) step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_frame(1'b0, 1'b1, -1, 1'b0);        // enable mid-frame: nothing yet
        run_frame(1'b1, 1'b1, -1, 1'b0);        // title shown
        run_frame(1'b1, 1'b0, -1, 1'b0);        // dropped mid-frame: kept to end
        run_frame(1'b0, 1'b0, -1, 1'b0);        // off
        run_frame(1'b0, 1'b1, -1, 1'b0);        // re-arm
        run_frame(1'b1, 1'b1, YPOS - 2, 1'b0);  // reset early in a shown frame
        for (int f = 0; f < 5; f++) begin
            run_frame(1'b1, 1'b1, -1, 1'($urandom_range(0, 1)));
        end
        run_frame(1'b1, 1'($urandom_range(0, 1)), -1, 1'b0);
        run_frame(1'b1, 1'b1, -1, 1'b0);
        repeat (4) step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
